// File: rtl/spi_master_param.sv
// Parametrised SPI master with registered SCK, CPOL/CPHA selection per frame,
// one-hot active-low chip selects and a BUSY/DONE handshake.
module spi_master_param #(
    parameter int  WIDTH = 8,
    parameter int  DIV   = 2,
    parameter int  CS_N  = 1,
    localparam int SW    = (CS_N > 1) ? $clog2(CS_N) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             CPOL,
    input  logic             CPHA,
    input  logic [SW-1:0]    CS_SEL,
    input  logic [WIDTH-1:0] DOUT,
    output logic [WIDTH-1:0] DIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CS_N-1:0]  CS,
    output logic             SCK,
    input  logic             MISO,
    output logic             MOSI
);

    localparam int EW  = $clog2(2 * WIDTH + 1);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * WIDTH);
    localparam logic [DCW-1:0] DIV_LOAD  = DCW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t           state_reg, state_next;
    logic [DCW-1:0]   div_cnt_reg;
    logic [EW-1:0]    edge_cnt_reg;
    logic [WIDTH-1:0] tx_reg, rx_reg, din_reg;
    logic [CS_N-1:0]  cs_reg;
    logic             sck_reg, cpol_reg, cpha_reg, busy_reg, done_reg;

    logic             div_tc, edge_odd;
    logic [EW-1:0]    edge_num;
    logic [CS_N-1:0]  cs_dec;
    logic             load_en, edge_en, sample_en, shift_en, finish_en;

    assign div_tc   = (div_cnt_reg == '0);
    assign edge_num = edge_cnt_reg + EW'(1);
    assign edge_odd = edge_num[0];

    // An out-of-range select matches no line, so every CS stays high.
    genvar gi;
    generate
        for (gi = 0; gi < CS_N; gi++) begin : g_cs_dec
            assign cs_dec[gi] = (CS_SEL != SW'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (START) state_next = LEAD;
            LEAD:  if (div_tc) state_next = XFER;
            XFER:  if (div_tc && edge_num == LAST_EDGE) state_next = TRAIL;
            TRAIL: if (div_tc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Edge k is produced at the terminal count ending LEAD (k=1) or XFER.
    always_comb begin
        load_en   = (state_reg == IDLE) && START;
        edge_en   = div_tc && (state_reg == LEAD || state_reg == XFER);
        finish_en = div_tc && (state_reg == TRAIL);
        sample_en = edge_en && (cpha_reg ? !edge_odd : edge_odd);
        shift_en  = edge_en && (cpha_reg ? (edge_odd && edge_num != EW'(1))
                                         : (!edge_odd && edge_num != LAST_EDGE));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            din_reg      <= '0;
            cs_reg       <= '1;
            sck_reg      <= 1'b0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= finish_en;

            if (load_en)
                div_cnt_reg <= DIV_LOAD;
            else if (state_reg != IDLE)
                div_cnt_reg <= div_tc ? DIV_LOAD : div_cnt_reg - DCW'(1);

            if (load_en)      edge_cnt_reg <= '0;
            else if (edge_en) edge_cnt_reg <= edge_num;

            // Tracking CPOL while idle puts SCK at its rest level before CS falls.
            if (state_reg == IDLE)       sck_reg <= CPOL;
            else if (edge_en)            sck_reg <= ~sck_reg;
            else if (state_reg == TRAIL) sck_reg <= cpol_reg;

            if (load_en) begin
                tx_reg   <= DOUT;
                rx_reg   <= '0;
                cpol_reg <= CPOL;
                cpha_reg <= CPHA;
                cs_reg   <= cs_dec;
                busy_reg <= 1'b1;
            end else begin
                if (shift_en)  tx_reg <= {tx_reg[WIDTH-2:0], 1'b0};
                if (sample_en) rx_reg <= {rx_reg[WIDTH-2:0], MISO};
                if (finish_en) begin
                    cs_reg   <= '1;
                    busy_reg <= 1'b0;
                    din_reg  <= rx_reg;
                end
            end
        end
    end

    assign DIN  = din_reg;
    assign BUSY = busy_reg;
    assign DONE = done_reg;
    assign CS   = cs_reg;
    assign SCK  = sck_reg;
    assign MOSI = tx_reg[WIDTH-1];

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: an 8-bit/DIV=2/single-CS instance and a
// 16-bit/DIV=1/four-CS instance, checked against hand-computed cycle counts and words.
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start_a, cpol_a, cpha_a, busy_a, done_a, sck_a, miso_a, mosi_a, loop_a;
    logic [0:0] cs_sel_a, cs_a;
    logic [7:0] dout_a, din_a;

    logic        start_b, cpol_b, cpha_b, busy_b, done_b, sck_b, mosi_b;
    logic [1:0]  cs_sel_b;
    logic [3:0]  cs_b;
    logic [15:0] dout_b, din_b;

    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    int         slv_fall = 0;

    int n_asserts = 0;
    int n_fail    = 0;

    spi_master_param #(.WIDTH(8), .DIV(2), .CS_N(1)) dut_a (
        .CLK(clk), .RST_N(rst_n), .START(start_a), .CPOL(cpol_a), .CPHA(cpha_a),
        .CS_SEL(cs_sel_a), .DOUT(dout_a), .DIN(din_a), .BUSY(busy_a), .DONE(done_a),
        .CS(cs_a), .SCK(sck_a), .MISO(miso_a), .MOSI(mosi_a)
    );

    spi_master_param #(.WIDTH(16), .DIV(1), .CS_N(4)) dut_b (
        .CLK(clk), .RST_N(rst_n), .START(start_b), .CPOL(cpol_b), .CPHA(cpha_b),
        .CS_SEL(cs_sel_b), .DOUT(dout_b), .DIN(din_b), .BUSY(busy_b), .DONE(done_b),
        .CS(cs_b), .SCK(sck_b), .MISO(mosi_b), .MOSI(mosi_b)
    );

    assign miso_a = loop_a ? mosi_a : slv_tx[7];

    // Mode-3 slave: first bit valid at CS fall, shifts on later leading (falling) edges.
    always @(negedge cs_a[0]) begin
        slv_tx   = 8'h3C;
        slv_rx   = 8'h00;
        slv_fall = 0;
    end
    always @(negedge sck_a) if (cs_a[0] == 1'b0) begin
        if (slv_fall > 0) slv_tx = {slv_tx[6:0], 1'b0};
        slv_fall++;
    end
    always @(posedge sck_a) if (cs_a[0] == 1'b0) slv_rx = {slv_rx[6:0], mosi_a};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame_a(input logic [7:0] d, input logic cp, input logic ch, input logic sel,
                           output int cs_cyc, output int first_edge, output int edges,
                           output int rises, output int done_cyc,
                           output logic sck1, output logic busy1);
        logic prev;
        @(negedge clk);
        cpol_a = cp; cpha_a = ch; cs_sel_a = sel;
        @(negedge clk);
        dout_a = d; start_a = 1'b1;
        prev = sck_a;
        cs_cyc = -1; first_edge = -1; edges = 0; rises = 0; done_cyc = -1;
        sck1 = 1'bx; busy1 = 1'bx;
        for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (c == 1) begin sck1 = sck_a; busy1 = busy_a; end
            if (cs_cyc < 0 && cs_a[0] === 1'b0) cs_cyc = c;
            if (sck_a !== prev) begin
                edges++;
                if (first_edge < 0) first_edge = c;
                if (sck_a) rises++;
            end
            prev = sck_a;
            if (done_a) done_cyc = c;
        end
    endtask

    task automatic frame_b(input logic [15:0] d, input logic [1:0] sel, input logic cp,
                           input logic ch, output logic [3:0] mask, output int first_edge,
                           output int edges, output int done_cyc);
        logic prev;
        @(negedge clk);
        cpol_b = cp; cpha_b = ch; cs_sel_b = sel;
        @(negedge clk);
        dout_b = d; start_b = 1'b1;
        prev = sck_b;
        mask = 4'b0000; first_edge = -1; edges = 0; done_cyc = -1;
        for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            mask = mask | ~cs_b;
            if (sck_b !== prev) begin
                edges++;
                if (first_edge < 0) first_edge = c;
            end
            prev = sck_b;
            if (done_b) done_cyc = c;
        end
    endtask

    initial begin
        int cs_cyc, first_edge, edges, rises, done_cyc, dones, last_done;
        logic sck1, busy1, done_seen;
        logic [3:0] mask;

        rst_n = 1'b0; loop_a = 1'b1;
        start_a = 1'b1; cpol_a = 1'b0; cpha_a = 1'b0; cs_sel_a = 1'b0; dout_a = 8'h00;
        start_b = 1'b1; cpol_b = 1'b0; cpha_b = 1'b0; cs_sel_b = 2'd0; dout_b = 16'h0000;

        // Reset held with START high.
        repeat (3) @(negedge clk);
        check("rst_cs_a", cs_a, 1'b1);
        check("rst_cs_b", cs_b, 4'hF);
        check("rst_sck", sck_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_din", din_a, 8'h00);
        start_a = 1'b0; start_b = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0 loopback.
        frame_a(8'hA5, 1'b0, 1'b0, 1'b0, cs_cyc, first_edge, edges, rises, done_cyc, sck1, busy1);
        $display("mode0 A5: cs_cyc=%0d first_edge=%0d edges=%0d done_cyc=%0d din=%h",
                 cs_cyc, first_edge, edges, done_cyc, din_a);
        check("m0_cs_cyc", cs_cyc, 1);
        check("m0_busy1", busy1, 1'b1);
        check("m0_first_edge", first_edge, 3);
        check("m0_edges", edges, 16);
        check("m0_rises", rises, 8);
        check("m0_done_cyc", done_cyc, 35);
        check("m0_din", din_a, 8'hA5);
        check("m0_cs_at_done", cs_a, 1'b1);
        check("m0_busy_at_done", busy_a, 1'b0);
        @(negedge clk);
        check("m0_done_pulse", done_a, 1'b0);

        // Mode 3 with slave model.
        loop_a = 1'b0;
        frame_a(8'hC3, 1'b1, 1'b1, 1'b0, cs_cyc, first_edge, edges, rises, done_cyc, sck1, busy1);
        $display("mode3 C3: sck1=%0b edges=%0d done_cyc=%0d din=%h slave_rx=%h",
                 sck1, edges, done_cyc, din_a, slv_rx);
        check("m3_sck_idle", sck1, 1'b1);
        check("m3_edges", edges, 16);
        check("m3_done_cyc", done_cyc, 35);
        check("m3_din", din_a, 8'h3C);
        check("m3_slave_rx", slv_rx, 8'hC3);
        check("m3_sck_at_done", sck_a, 1'b1);
        loop_a = 1'b1;

        // START held high: second frame starts in the DONE cycle.
        @(negedge clk);
        cpol_a = 1'b0; cpha_a = 1'b0;
        @(negedge clk);
        dout_a = 8'h5A; start_a = 1'b1; dones = 0; last_done = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 35) check("b2b_cs_high_at_done", cs_a, 1'b1);
            if (c == 36) begin
                check("b2b_cs_fall", cs_a, 1'b0);
                start_a = 1'b0;
            end
            if (done_a) begin dones++; last_done = c; end
        end
        $display("b2b held: dones=%0d last_done=%0d din=%h", dones, last_done, din_a);
        check("b2b_dones", dones, 2);
        check("b2b_last_done", last_done, 70);
        check("b2b_din", din_a, 8'h5A);

        // START pulses while busy are ignored.
        @(negedge clk);
        dout_a = 8'h0F; start_a = 1'b1; dones = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start_a = (c == 5 || c == 20 || c == 34);
            if (done_a) dones++;
        end
        $display("busy pulses: dones=%0d busy=%0b din=%h", dones, busy_a, din_a);
        check("ign_dones", dones, 1);
        check("ign_busy", busy_a, 1'b0);
        check("ign_din", din_a, 8'h0F);

        // Reset at SCK edge 5.
        @(negedge clk);
        dout_a = 8'hFF; start_a = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        check("mid_edge5_sck", sck_a, 1'b1);
        rst_n = 1'b0;
        #1;
        $display("mid reset: cs=%b sck=%0b busy=%0b din=%h", cs_a, sck_a, busy_a, din_a);
        check("mid_rst_cs", cs_a, 1'b1);
        check("mid_rst_sck", sck_a, 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_din", din_a, 8'h00);
        done_seen = 1'b0;
        repeat (2) begin @(negedge clk); done_seen = done_seen | done_a; end
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin @(negedge clk); done_seen = done_seen | done_a; end
        check("mid_no_done", done_seen, 1'b0);
        frame_a(8'h96, 1'b0, 1'b0, 1'b0, cs_cyc, first_edge, edges, rises, done_cyc, sck1, busy1);
        $display("after reset 96: done_cyc=%0d din=%h", done_cyc, din_a);
        check("post_rst_done_cyc", done_cyc, 35);
        check("post_rst_din", din_a, 8'h96);

        // Out-of-range select on a single-CS instance.
        frame_a(8'h3E, 1'b0, 1'b0, 1'b1, cs_cyc, first_edge, edges, rises, done_cyc, sck1, busy1);
        $display("sel oob 3E: cs_cyc=%0d done_cyc=%0d din=%h", cs_cyc, done_cyc, din_a);
        check("oob_no_cs", cs_cyc, -1);
        check("oob_done_cyc", done_cyc, 35);
        check("oob_din", din_a, 8'h3E);

        // 16-bit, DIV=1, four chip selects.
        frame_b(16'hBEEF, 2'd2, 1'b0, 1'b0, mask, first_edge, edges, done_cyc);
        $display("w16 sel2 BEEF: mask=%b first_edge=%0d edges=%0d done_cyc=%0d din=%h",
                 mask, first_edge, edges, done_cyc, din_b);
        check("w16_sel2_mask", mask, 4'b0100);
        check("w16_first_edge", first_edge, 2);
        check("w16_edges", edges, 32);
        check("w16_done_cyc", done_cyc, 34);
        check("w16_din_beef", din_b, 16'hBEEF);
        frame_b(16'h1234, 2'd3, 1'b1, 1'b1, mask, first_edge, edges, done_cyc);
        $display("w16 sel3 1234: mask=%b edges=%0d done_cyc=%0d din=%h",
                 mask, edges, done_cyc, din_b);
        check("w16_sel3_mask", mask, 4'b1000);
        check("w16_m3_edges", edges, 32);
        check("w16_m3_done_cyc", done_cyc, 34);
        check("w16_din_1234", din_b, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
